lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Load/store sequencer between the core datapath and the data-memory port.
- Takes the decoder's memory_require / memory_write_enable / memory_size plus the ALU-computed address.
- Drives a req/gnt/rvalid memory handshake and stalls the core until the access completes.
- Aligns store data and byte enables, and extracts and extends load data.

Parameters:
- ADDR_WIDTH, 32, width of core and memory address buses.
- DATA_WIDTH, 32, data bus width; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- core_req  in  1  memory_require from decoder
- core_we  in  1  memory_write_enable from decoder
- core_size  in  3  memory_size (DATA_SIZE_* encoding)
- core_addr  in  ADDR_WIDTH  byte address from ALU
- core_wd  in  32  store data (rs2)
- core_rd  out  32  load result, extended
- core_stall  out  1  hold PC and pipeline
- core_fault  out  1  one-cycle pulse, access rejected
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits = 0
- mem_wd  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response/ack valid (reads and writes)
- mem_rdata  in  32  read data

Behaviour:
- Interface: one clock clk; rst is asynchronous and active-high.
- rst asserted at any time:
  - state -> IDLE immediately.
  - All outputs 0: core_rd, core_stall, core_fault, mem_req, mem_we, mem_be, mem_addr, mem_wd.
  - Any in-flight transaction is abandoned; a late mem_rvalid after reset is ignored in IDLE.
- IDLE:
  - core_stall = core_req & ~reject, combinational.
  - On core_req & ~reject: register we, size, addr[1:0], aligned address, be and wd; go to REQ.
- REQ:
  - mem_req=1; mem_we, mem_be, mem_addr, mem_wd driven from registers and held stable until mem_gnt.
  - core_stall=1.
  - On mem_gnt go to WAIT; else stay (unbounded wait).
- WAIT:
  - mem_req=0, core_stall=1.
  - On mem_rvalid: register extracted load data into core_rd (writes leave core_rd unchanged); go to DONE.
  - mem_rvalid in the same cycle as mem_gnt (in REQ) is not legal.
- DONE:
  - core_stall=0 for exactly one cycle; core_rd valid; core retires the instruction at this edge.
  - Return to IDLE without re-sampling core_req this cycle.
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid the next cycle): 3 stall cycles, result in cycle 4.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- mem_wd:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load extract:
  - lane = rdata >> (8*addr[1:0]).
  - BYTE: sign-extend bit 7. U_BYTE: zero-extend.
  - HALF: sign-extend bit 15. U_HALF: zero-extend.
  - WORD: unchanged.
- Reject (core_fault=1 for one cycle in IDLE; no memory transaction; core_stall=0):
  - core_size not one of the five DATA_SIZE_* codes.
  - Misalignment, only when the optional feature is enabled.
  - For stores, only BYTE, HALF and WORD are accepted.
- core_req deasserting mid-transaction is ignored; the transaction completes.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - Half access with addr[0]=1 is rejected.
  - Word access with addr[1:0]≠0 is rejected.
  - Rejects pulse core_fault in IDLE as above.
- Undefined:
  - No alignment check; low address bits are silently masked.
  - Half uses addr[1] only; word ignores addr[1:0].
  - core_fault fires only on illegal size.

Decomposition:
- defines.v gains:
  - LSU state encodings: LSU_IDLE=2'd0, LSU_REQ=2'd1, LSU_WAIT=2'd2, LSU_DONE=2'd3.
  - Byte-enable constants.
- Existing DATA_SIZE_* codes are reused unchanged.
- Sub-module lsu_data_align (combinational): size + addr[1:0] + wd/rdata -> be, replicated wd, extended rd. Instantiated once.
- FSM and registers stay in lsu_controller.

Test Plan:
- LW addr 0x104, mem_rdata 0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_addr 0x104, be 1111; stall high 3 cycles; core_rd 0xDEADBEEF in cycle 4.
- LB addr 0x103, rdata 0x80112233 -> be 1000; core_rd 0xFFFFFF80. Same access as LBU -> core_rd 0x00000080.
- SH addr 0x202, wd 0x0000ABCD, gnt delayed 5 cycles -> mem_req held 6 cycles with stable be 1100 and mem_wd 0xABCDABCD; stall until DONE.
- rst raised while in WAIT -> mem_req, core_stall and core_rd are 0 the same cycle; a following rvalid does not change core_rd.
- core_size=3'b011 with core_req -> core_fault pulses 1 cycle, mem_req stays 0, no stall.
- LSU_MISALIGN_CHECK_EN defined, LW addr 0x102 -> core_fault pulse, no mem_req. Undefined -> mem_addr 0x100, be 1111.

Source files
------------

// File: rtl/lsu_controller_pkg.sv
// Shared LSU types: memory-size codes, FSM state encodings, byte-enable masks.
// Misalignment helper is consumed only when LSU_MISALIGN_CHECK_EN is defined.
package lsu_controller_pkg;

    localparam logic [2:0] DATA_SIZE_BYTE   = 3'b000;
    localparam logic [2:0] DATA_SIZE_HALF   = 3'b001;
    localparam logic [2:0] DATA_SIZE_WORD   = 3'b010;
    localparam logic [2:0] DATA_SIZE_U_BYTE = 3'b100;
    localparam logic [2:0] DATA_SIZE_U_HALF = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
    localparam logic [3:0] LSU_BE_HALF = 4'b0011;
    localparam logic [3:0] LSU_BE_WORD = 4'b1111;

    function automatic logic size_valid(input logic [2:0] size);
        case (size)
            DATA_SIZE_BYTE, DATA_SIZE_HALF, DATA_SIZE_WORD,
            DATA_SIZE_U_BYTE, DATA_SIZE_U_HALF: size_valid = 1'b1;
            default:                            size_valid = 1'b0;
        endcase
    endfunction

    function automatic logic store_size_ok(input logic [2:0] size);
        case (size)
            DATA_SIZE_BYTE, DATA_SIZE_HALF, DATA_SIZE_WORD: store_size_ok = 1'b1;
            default:                                        store_size_ok = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            DATA_SIZE_HALF, DATA_SIZE_U_HALF: misaligned = addr_lo[0];
            DATA_SIZE_WORD:                   misaligned = |addr_lo;
            default:                          misaligned = 1'b0;
        endcase
    endfunction

    // Without the alignment check, halves ignore addr[0] and words ignore addr[1:0].
    function automatic logic [1:0] lane_offset(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            DATA_SIZE_BYTE, DATA_SIZE_U_BYTE: lane_offset = addr_lo;
            DATA_SIZE_HALF, DATA_SIZE_U_HALF: lane_offset = {addr_lo[1], 1'b0};
            default:                          lane_offset = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and replicated store data from size/addr,
// plus load lane extraction with sign or zero extension.
module lsu_data_align
    import lsu_controller_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o
);

    logic [1:0]  off;
    logic [31:0] lane;

    always_comb begin
        off  = lane_offset(size_i, addr_lo_i);
        lane = rdata_i >> {off, 3'b000};
        be_o = '0;
        wd_o = '0;
        rd_o = '0;
        case (size_i)
            DATA_SIZE_BYTE: begin
                be_o = LSU_BE_BYTE << off;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {{24{lane[7]}}, lane[7:0]};
            end
            DATA_SIZE_U_BYTE: begin
                be_o = LSU_BE_BYTE << off;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {24'h0, lane[7:0]};
            end
            DATA_SIZE_HALF: begin
                be_o = LSU_BE_HALF << off;
                wd_o = {2{wd_i[15:0]}};
                rd_o = {{16{lane[15]}}, lane[15:0]};
            end
            DATA_SIZE_U_HALF: begin
                be_o = LSU_BE_HALF << off;
                wd_o = {2{wd_i[15:0]}};
                rd_o = {16'h0, lane[15:0]};
            end
            DATA_SIZE_WORD: begin
                be_o = LSU_BE_WORD;
                wd_o = wd_i;
                rd_o = lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: IDLE -> REQ (hold until gnt) -> WAIT (until rvalid) -> DONE, stalling the core.
// Optional alignment rejection enabled by LSU_MISALIGN_CHECK_EN.
module lsu_controller
    import lsu_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_size,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wd,
    output logic [DATA_WIDTH-1:0] core_rd,
    output logic                  core_stall,
    output logic                  core_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;

    logic                  misalign;
    logic                  reject;
    logic                  accept;
    logic [2:0]            al_size;
    logic [1:0]            al_addr_lo;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wd;
    logic [DATA_WIDTH-1:0] al_rd;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = misaligned(core_size, core_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign reject = ~size_valid(core_size) | (core_we & ~store_size_ok(core_size)) | misalign;
    assign accept = core_req & ~reject;

    // One aligner serves both directions: store lanes are captured in IDLE, loads extracted in WAIT.
    assign al_size    = (state_q == LSU_IDLE) ? core_size       : size_q;
    assign al_addr_lo = (state_q == LSU_IDLE) ? core_addr[1:0]  : addr_lo_q;

    lsu_data_align u_align (
        .size_i    (al_size),
        .addr_lo_i (al_addr_lo),
        .wd_i      (core_wd),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wd_o      (al_wd),
        .rd_o      (al_rd)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_lo_d  = addr_lo_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wd_d       = wd_q;
        rd_d       = rd_q;
        core_stall = 1'b0;
        core_fault = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wd     = '0;
        case (state_q)
            LSU_IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                core_stall = accept & ~rst;
                core_fault = core_req & reject & ~rst;
                if (accept) begin
                    we_d      = core_we;
                    size_d    = core_size;
                    addr_lo_d = core_addr[1:0];
                    addr_d    = {core_addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d      = al_be;
                    wd_d      = al_wd;
                    state_d   = LSU_REQ;
                end
            end
            LSU_REQ: begin
                core_stall = 1'b1;
                mem_req    = 1'b1;
                mem_we     = we_q;
                mem_be     = be_q;
                mem_addr   = addr_q;
                mem_wd     = wd_q;
                if (mem_gnt) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                core_stall = 1'b1;
                if (mem_rvalid) begin
                    if (!we_q) begin
                        rd_d = al_rd;
                    end
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            we_q      <= 1'b0;
            size_q    <= '0;
            addr_lo_q <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_lo_q <= addr_lo_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
        end
    end

    assign core_rd = rd_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: expected transactions queued at drive time, checked on mem_req and at DONE.
// Covers LSU_MISALIGN_CHECK_EN in both builds.
module tb_lsu_controller;
    import lsu_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall, core_fault;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rd;
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    lsu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .core_fault (core_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model answers gnt after gnt_dly refused REQ cycles, then rvalid the following cycle.
    task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                              input int gnt_dly, input logic drop,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_rd);
        exp_t e;
        int   stalls;
        int   reqs;
        logic rv_next;
        logic done;
        e.we     = we;
        e.addr   = e_addr;
        e.be     = e_be;
        e.wd     = e_wd;
        e.rd     = we ? last_rd : e_rd;
        e.stalls = gnt_dly + 3;
        e.reqs   = gnt_dly + 1;
        if (!we) last_rd = e_rd;
        sb.push_back(e);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr;
        core_wd = wd; mem_rdata = rdata;
        stalls = 0; reqs = 0; rv_next = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (drop) core_req = 1'b0;
            end
            mem_gnt = 1'b0;
            mem_rvalid = rv_next;
            rv_next = 1'b0;
            #1;
            if (mem_req) begin
                reqs++;
                chk({tag, " mem_addr"}, mem_addr, sb[0].addr);
                chk({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, sb[0].be});
                chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, sb[0].we});
                if (we) chk({tag, " mem_wd"}, mem_wd, sb[0].wd);
                if (reqs > gnt_dly) begin
                    mem_gnt = 1'b1;
                    rv_next = 1'b1;
                end
            end
            if (core_stall) stalls++;
            else if (reqs > 0) begin
                done = 1'b1;
                e = sb.pop_front();
                chk({tag, " core_rd"}, core_rd, e.rd);
                chk({tag, " stall_cycles"}, stalls, e.stalls);
                chk({tag, " req_cycles"}, reqs, e.reqs);
            end
        end
        if (!done) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
            e = sb.pop_front();
        end
        core_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic expect_fault(input string tag, input logic we, input logic [2:0] size,
                                input logic [31:0] addr);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = 32'h1234_5678;
        #1;
        chk({tag, " fault"}, {31'h0, core_fault}, 32'd1);
        chk({tag, " stall"}, {31'h0, core_stall}, 32'd0);
        chk({tag, " mem_req"}, {31'h0, mem_req}, 32'd0);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk({tag, " fault_end"}, {31'h0, core_fault}, 32'd0);
        chk({tag, " mem_req_after"}, {31'h0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = DATA_SIZE_WORD;
        core_addr = '0; core_wd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        core_req = 1'b1;
        #1;
        chk("rst core_stall", {31'h0, core_stall}, 32'd0);
        chk("rst mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst mem_be", {28'h0, mem_be}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst core_rd", core_rd, 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_access("LW",  1'b0, DATA_SIZE_WORD,   32'h104, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h104, 4'b1111, 32'h0, 32'hDEADBEEF);
        run_access("LB",  1'b0, DATA_SIZE_BYTE,   32'h103, 32'h0, 32'h80112233, 0, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        run_access("LBU", 1'b0, DATA_SIZE_U_BYTE, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
        run_access("SH",  1'b1, DATA_SIZE_HALF,   32'h202, 32'h0000ABCD, 32'h0, 5, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
        run_access("LH",  1'b0, DATA_SIZE_HALF,   32'h202, 32'h0, 32'h80017FFF, 0, 1'b0, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
        run_access("LHU", 1'b0, DATA_SIZE_U_HALF, 32'h200, 32'h0, 32'h8001F00F, 2, 1'b1, 32'h200, 4'b0011, 32'h0, 32'h0000F00F);
        run_access("SB",  1'b1, DATA_SIZE_BYTE,   32'h101, 32'hFFFFFF5A, 32'h0, 0, 1'b0, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0);
        run_access("SW",  1'b1, DATA_SIZE_WORD,   32'h300, 32'h12345678, 32'h0, 3, 1'b1, 32'h300, 4'b1111, 32'h12345678, 32'h0);
        run_access("LB1", 1'b0, DATA_SIZE_BYTE,   32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 32'h100, 4'b0010, 32'h0, 32'h0000007F);

        expect_fault("size011", 1'b0, 3'b011, 32'h100);
        expect_fault("size111", 1'b0, 3'b111, 32'h100);
        expect_fault("SBU", 1'b1, DATA_SIZE_U_BYTE, 32'h100);
        expect_fault("SHU", 1'b1, DATA_SIZE_U_HALF, 32'h100);

`ifdef LSU_MISALIGN_CHECK_EN
        expect_fault("LW mis", 1'b0, DATA_SIZE_WORD, 32'h102);
        expect_fault("LH mis", 1'b0, DATA_SIZE_HALF, 32'h101);
        run_access("LH al", 1'b0, DATA_SIZE_HALF, 32'h102, 32'h0, 32'h7ABC0000, 0, 1'b0, 32'h100, 4'b1100, 32'h0, 32'h00007ABC);
`else
        run_access("LW mis", 1'b0, DATA_SIZE_WORD, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
        run_access("LH mis", 1'b0, DATA_SIZE_HALF, 32'h101, 32'h0, 32'h7ABC8123, 0, 1'b0, 32'h100, 4'b0011, 32'h0, 32'hFFFF8123);
`endif

        // Reset while waiting for rvalid; a late rvalid must not reach core_rd.
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = DATA_SIZE_WORD; core_addr = 32'h104;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("rstw in_req", {31'h0, mem_req}, 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("rstw wait_stall", {31'h0, core_stall}, 32'd1);
        chk("rstw wait_req", {31'h0, mem_req}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rstw mem_req", {31'h0, mem_req}, 32'd0);
        chk("rstw core_stall", {31'h0, core_stall}, 32'd0);
        chk("rstw core_rd", core_rd, 32'd0);
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late rvalid core_rd", core_rd, 32'd0);
        chk("late rvalid stall", {31'h0, core_stall}, 32'd0);
        chk("late rvalid mem_req", {31'h0, mem_req}, 32'd0);
        last_rd = '0;

        run_access("LW post", 1'b0, DATA_SIZE_WORD, 32'h40, 32'h0, 32'h0BADCAFE, 1, 1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BADCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
